// File: rtl/pc_pkg.sv
// Shared fetch-PC definitions: default widths/vectors and the next-PC source selector.
package pc_pkg;
    localparam int          XLEN        = 32;
    localparam logic [31:0] RESET_VEC   = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC    = 32'h0000_0100;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_MRET,
        SEL_REDIR,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } pc_sel_t;
endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: newest entry sits just below ptr; a push when full
// overwrites the oldest entry.
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            swap,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;

    assign top_idx = ptr - PTR_W'(1);
    assign top     = entries[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            entries[ptr] <= push_data;
            ptr          <= ptr + PTR_W'(1);
            if (!full) count <= count + CNT_W'(1);
        end else if (pop) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end else if (swap) begin
            entries[top_idx] <= push_data;
        end
    end
endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator: prioritised next-PC selection (trap, mret, redirect, stall, RAS, sequential)
// with an EPC register and a return-address stack for return prediction.
module pc_gen_ras
    import pc_pkg::*;
#(
    parameter int              XLEN      = pc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(pc_pkg::RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(pc_pkg::TRAP_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            mret_valid,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc_out,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);
    pc_sel_t         sel;
    logic            mis_redir;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_en;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_swap;

    assign pc_plus4  = pc_out + XLEN'(INSTR_BYTES);
    assign mis_redir = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_comb begin
        sel = SEL_SEQ;
        if (trap_valid || mis_redir) sel = SEL_TRAP;
        else if (mret_valid)         sel = SEL_MRET;
        else if (redirect_valid)     sel = SEL_REDIR;
        else if (stall)              sel = SEL_HOLD;
        else if (ret && !ras_empty)  sel = SEL_RAS;
    end

    always_comb begin
        pc_next = pc_plus4;
        case (sel)
            SEL_TRAP:  pc_next = TRAP_VEC;
            SEL_MRET:  pc_next = epc_out;
            SEL_REDIR: pc_next = redirect_target;
            SEL_HOLD:  pc_next = pc_out;
            SEL_RAS:   pc_next = ras_top;
            default:   pc_next = pc_plus4;
        endcase
    end

    // call+ret with a live entry swaps the top; with an empty stack it degrades to a push
    assign ras_en   = (sel == SEL_RAS) || (sel == SEL_SEQ);
    assign ras_swap = ras_en && call && ret && !ras_empty;
    assign ras_push = ras_en && call && !(ret && !ras_empty);
    assign ras_pop  = ras_en && ret && !call && !ras_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out     <= RESET_VEC;
            epc_out    <= '0;
            misaligned <= 1'b0;
        end else begin
            pc_out     <= pc_next;
            misaligned <= !trap_valid && mis_redir;
            if (sel == SEL_TRAP) epc_out <= pc_out;
        end
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .swap      (ras_swap),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed scenarios with literal expectations plus randomized traffic,
// all checked against a queue-based reference model.
module tb_pc_gen_ras;
    localparam int          DEPTH = 4;
    localparam logic [31:0] TVEC  = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 0, redirect_valid = 0, trap_valid = 0, mret_valid = 0, call = 0, ret = 0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc_out, pc_plus4, epc_out;
    logic        misaligned, ras_empty, ras_full;

    pc_gen_ras #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(TVEC), .RAS_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .mret_valid      (mret_valid),
        .call            (call),
        .ret             (ret),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .epc_out         (epc_out),
        .misaligned      (misaligned),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full)
    );

    always #5 clk = ~clk;

    // reference model
    logic [31:0] m_pc = '0, m_epc = '0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras[$];

    // literal expectations for the next compare
    logic        lit_pc_en = 0, lit_epc_en = 0, lit_mis_en = 0, lit_emp_en = 0, lit_full_en = 0;
    logic [31:0] lit_pc = '0, lit_epc = '0;
    logic        lit_mis = 0, lit_emp = 0, lit_full = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        m_pc = '0; m_epc = '0; m_mis = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [31:0] p4, nxt;
        if (!reset) return;
        p4    = m_pc + 32'd4;
        m_mis = 1'b0;
        if (trap_valid) begin
            m_epc = m_pc; m_pc = TVEC;
        end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            m_epc = m_pc; m_pc = TVEC; m_mis = 1'b1;
        end else if (mret_valid) begin
            m_pc = m_epc;
        end else if (redirect_valid) begin
            m_pc = redirect_target;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret && m_ras.size() > 0) begin
            nxt = m_ras[m_ras.size()-1];
            if (call) m_ras[m_ras.size()-1] = p4;
            else      void'(m_ras.pop_back());
            m_pc = nxt;
        end else begin
            if (call) begin
                m_ras.push_back(p4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = p4;
        end
    endtask

    always @(negedge clk) begin
        n_vec++;
        if (pc_out !== m_pc || pc_plus4 !== (m_pc + 32'd4) || epc_out !== m_epc ||
            misaligned !== m_mis || ras_empty !== (m_ras.size() == 0) ||
            ras_full !== (m_ras.size() == DEPTH)) begin
            n_err++;
            $display("FAIL model t=%0t: got pc=%h p4=%h epc=%h mis=%b emp=%b full=%b, expected pc=%h p4=%h epc=%h mis=%b emp=%b full=%b",
                     $time, pc_out, pc_plus4, epc_out, misaligned, ras_empty, ras_full,
                     m_pc, m_pc + 32'd4, m_epc, m_mis, m_ras.size() == 0, m_ras.size() == DEPTH);
        end
        if (lit_pc_en) begin
            n_vec++;
            if (pc_out !== lit_pc || m_pc !== lit_pc) begin
                n_err++;
                $display("FAIL lit_pc t=%0t: dut=%h model=%h expected=%h", $time, pc_out, m_pc, lit_pc);
            end
        end
        if (lit_epc_en) begin
            n_vec++;
            if (epc_out !== lit_epc || m_epc !== lit_epc) begin
                n_err++;
                $display("FAIL lit_epc t=%0t: dut=%h model=%h expected=%h", $time, epc_out, m_epc, lit_epc);
            end
        end
        if (lit_mis_en) begin
            n_vec++;
            if (misaligned !== lit_mis || m_mis !== lit_mis) begin
                n_err++;
                $display("FAIL lit_mis t=%0t: dut=%b model=%b expected=%b", $time, misaligned, m_mis, lit_mis);
            end
        end
        if (lit_emp_en) begin
            n_vec++;
            if (ras_empty !== lit_emp || (m_ras.size() == 0) !== lit_emp) begin
                n_err++;
                $display("FAIL lit_empty t=%0t: dut=%b expected=%b", $time, ras_empty, lit_emp);
            end
        end
        if (lit_full_en) begin
            n_vec++;
            if (ras_full !== lit_full || (m_ras.size() == DEPTH) !== lit_full) begin
                n_err++;
                $display("FAIL lit_full t=%0t: dut=%b expected=%b", $time, ras_full, lit_full);
            end
        end
    end

    // apply current inputs for one clock, compare at negedge, then return to idle inputs
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        lit_pc_en = 0; lit_epc_en = 0; lit_mis_en = 0; lit_emp_en = 0; lit_full_en = 0;
        stall = 0; redirect_valid = 0; trap_valid = 0; mret_valid = 0; call = 0; ret = 0;
    endtask

    task automatic expect_pc(input logic [31:0] v);
        lit_pc_en = 1; lit_pc = v;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        expect_pc(32'h0); lit_emp_en = 1; lit_emp = 1;
        @(negedge clk); #1;
        reset = 1'b1;

        // sequential fetch out of reset
        expect_pc(32'h4); lit_emp_en = 1; lit_emp = 1; tick();
        expect_pc(32'h8); tick();
        expect_pc(32'hC); tick();

        // stall holds, redirect overrides stall
        expect_pc(32'h10); tick();
        stall = 1; expect_pc(32'h10); tick();
        stall = 1; expect_pc(32'h10); tick();
        stall = 1; redir(32'h200); expect_pc(32'h200); tick();

        // call / ret round trip
        redir(32'h20); expect_pc(32'h20); tick();
        call = 1; expect_pc(32'h24); lit_emp_en = 1; lit_emp = 0; tick();
        redir(32'h80); expect_pc(32'h80); tick();
        ret = 1; expect_pc(32'h24); lit_emp_en = 1; lit_emp = 1; tick();

        // overflow wraps onto oldest entry
        redir(32'h0); expect_pc(32'h0); tick();
        for (int i = 1; i <= 5; i++) begin
            call = 1; expect_pc(32'(i * 4));
            if (i == 5) begin lit_full_en = 1; lit_full = 1; end
            tick();
        end
        ret = 1; expect_pc(32'h14); tick();
        ret = 1; expect_pc(32'h10); tick();
        ret = 1; expect_pc(32'hC); tick();
        ret = 1; expect_pc(32'h8); lit_emp_en = 1; lit_emp = 1; tick();
        ret = 1; expect_pc(32'hC); tick();

        // misaligned redirect, mret, trap beats mret
        redir(32'h40); expect_pc(32'h40); tick();
        redir(32'h103); expect_pc(32'h100); lit_epc_en = 1; lit_epc = 32'h40;
        lit_mis_en = 1; lit_mis = 1; tick();
        expect_pc(32'h104); lit_mis_en = 1; lit_mis = 0; tick();
        mret_valid = 1; expect_pc(32'h40); tick();
        trap_valid = 1; mret_valid = 1; expect_pc(32'h100); lit_epc_en = 1; lit_epc = 32'h40; tick();

        // address wrap
        redir(32'hFFFF_FFFC); expect_pc(32'hFFFF_FFFC); tick();
        expect_pc(32'h0); tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall      = ($urandom_range(0, 99) < 15);
            trap_valid = ($urandom_range(0, 99) < 3);
            mret_valid = ($urandom_range(0, 99) < 3);
            call       = ($urandom_range(0, 99) < 25);
            ret        = ($urandom_range(0, 99) < 25);
            redirect_valid = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       redirect_target = $urandom();
                1:       redirect_target = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
                default: redirect_target = 32'($urandom_range(0, 255)) << 2;
            endcase
            tick();
        end

        // async reset between edges
        call = 1; tick();
        call = 1;
        @(posedge clk);
        model_step();
        #2;
        reset = 1'b0;
        model_reset();
        call = 0;
        expect_pc(32'h0); lit_emp_en = 1; lit_emp = 1;
        @(negedge clk); #1;
        lit_pc_en = 0; lit_emp_en = 0;
        expect_pc(32'h0); call = 1; tick();
        reset = 1'b1;
        expect_pc(32'h4); tick();
        expect_pc(32'h8); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
